// File: rtl/ready_valid_master.sv
// Byte FIFO feeding a registered valid/ready bus master, with an optional forced
// idle gap after every completed transfer and a wrapping count of transfers.
module ready_valid_master #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [7:0]               push_data,
   output logic                     full,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level,
   output logic [7:0]               data,
   output logic                     master_valid,
   input  logic                     slave_ready,
   output logic [15:0]              sent_count
);

   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam int unsigned LevelW = PtrW + 1;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StGap
   } state_e;

   state_e             state_q, state_d;
   logic [3:0]         gap_q, gap_d;
   logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LevelW-1:0]  level_q, level_d;
   logic [7:0]         mem_q [DEPTH];
   logic [7:0]         data_q, data_d;
   logic               valid_q, valid_d;
   logic               overflow_q;
   logic [15:0]        sent_q;

   logic               xfer;
   logic               not_empty;
   logic               full_int;
   logic               push_ok;
   logic               pop;

   assign xfer      = valid_q & slave_ready;
   assign not_empty = (level_q != '0);
   assign full_int  = (level_q == LevelW'(DEPTH));
   // A push while full is dropped even if the same edge pops an entry.
   assign push_ok   = push & ~full_int;

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (not_empty) begin
               pop     = 1'b1;
               state_d = StSend;
            end
         end
         StSend: begin
            if (xfer) begin
               if (GAP_CYCLES != 0) begin
                  gap_d   = 4'(GAP_CYCLES);
                  state_d = StGap;
               end else if (not_empty) begin
                  pop = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StGap: begin
            gap_d = gap_q - 4'd1;
            if (gap_q <= 4'd1) begin
               gap_d = 4'd0;
               if (not_empty) begin
                  pop     = 1'b1;
                  state_d = StSend;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
            gap_d   = 4'd0;
         end
      endcase
   end

   always_comb begin
      data_d  = pop ? mem_q[rd_ptr_q] : data_q;
      valid_d = (state_d == StSend);
      level_d = level_q;
      if (push_ok && !pop) begin
         level_d = level_q + 1'b1;
      end else if (!push_ok && pop) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         gap_q      <= 4'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         data_q     <= 8'd0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
         sent_q     <= 16'd0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         level_q <= level_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && full_int) begin
            overflow_q <= 1'b1;
         end
         if (xfer) begin
            sent_q <= sent_q + 16'd1;
         end
      end
   end

   // Storage needs no reset: pointers and level define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign full         = full_int;
   assign overflow     = overflow_q;
   assign level        = level_q;
   assign data         = data_q;
   assign master_valid = valid_q;
   assign sent_count   = sent_q;

endmodule

// File: tb/tb_ready_valid_master.sv
// Bench for ready_valid_master: one instance without gap, one with a 2-cycle gap,
// both checked against a queue-based transaction model of the bus master.
module tb_ready_valid_master;

   localparam int DEPTH = 4;
   localparam int GAP0  = 0;
   localparam int GAP1  = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        push0, push1;
   logic [7:0]  pd0, pd1;
   logic        rdy0, rdy1;
   logic        full0, full1, ovf0, ovf1, valid0, valid1;
   logic [2:0]  level0, level1;
   logic [7:0]  data0, data1;
   logic [15:0] sent0, sent1;

   int n_chk = 0;
   int n_err = 0;

   // Model state per instance
   logic [7:0] mq [2][$];
   bit         mv [2];
   logic [7:0] md [2];
   int         mgap [2];
   bit         movf [2];
   int         msent [2];

   always #5 clk = ~clk;

   ready_valid_master #(.DEPTH(DEPTH), .GAP_CYCLES(GAP0)) dut0 (
      .clk(clk), .rst_n(rst_n), .push(push0), .push_data(pd0), .full(full0),
      .overflow(ovf0), .level(level0), .data(data0), .master_valid(valid0),
      .slave_ready(rdy0), .sent_count(sent0)
   );

   ready_valid_master #(.DEPTH(DEPTH), .GAP_CYCLES(GAP1)) dut1 (
      .clk(clk), .rst_n(rst_n), .push(push1), .push_data(pd1), .full(full1),
      .overflow(ovf1), .level(level1), .data(data1), .master_valid(valid1),
      .slave_ready(rdy1), .sent_count(sent1)
   );

   function automatic int gap_of(input int i);
      return (i == 0) ? GAP0 : GAP1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mq[i].delete();
         mv[i]    = 1'b0;
         md[i]    = 8'd0;
         mgap[i]  = 0;
         movf[i]  = 1'b0;
         msent[i] = 0;
      end
   endtask

   // One clock edge of the bus master described in terms of transfers and a byte queue.
   task automatic model_step(input int i, input bit p, input logic [7:0] pdat, input bit r);
      bit push_ok;
      push_ok = p && (mq[i].size() < DEPTH);
      if (mv[i]) begin
         if (r) begin
            msent[i] = (msent[i] + 1) % 65536;
            if (gap_of(i) > 0) begin
               mv[i]   = 1'b0;
               mgap[i] = gap_of(i);
            end else if (mq[i].size() > 0) begin
               md[i] = mq[i].pop_front();
            end else begin
               mv[i] = 1'b0;
            end
         end
      end else if (mgap[i] > 0) begin
         if (mgap[i] == 1 && mq[i].size() > 0) begin
            md[i] = mq[i].pop_front();
            mv[i] = 1'b1;
         end
         mgap[i]--;
      end else if (mq[i].size() > 0) begin
         md[i] = mq[i].pop_front();
         mv[i] = 1'b1;
      end
      if (push_ok) mq[i].push_back(pdat);
      else if (p) movf[i] = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0, push0, pd0, rdy0);
      model_step(1, push1, pd1, rdy1);
      @(negedge clk);
   endtask

   // Data is only meaningful while valid, so it is masked otherwise.
   function automatic logic [29:0] dut_snap(input int i);
      if (i == 0) return {valid0, valid0 ? data0 : 8'd0, level0, full0, ovf0, sent0};
      return {valid1, valid1 ? data1 : 8'd0, level1, full1, ovf1, sent1};
   endfunction

   function automatic logic [29:0] mod_snap(input int i);
      return {mv[i], mv[i] ? md[i] : 8'd0, 3'(mq[i].size()), mq[i].size() == DEPTH,
              movf[i], 16'(msent[i])};
   endfunction

   task automatic apply_reset();
      push0 = 1'b0; push1 = 1'b0; pd0 = 8'd0; pd1 = 8'd0; rdy0 = 1'b0; rdy1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      push0 = 1'b0; push1 = 1'b0; pd0 = 8'd0; pd1 = 8'd0; rdy0 = 1'b1; rdy1 = 1'b1;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         n_chk++;
         if (dut_snap(i) !== 30'd0) begin
            n_err++;
            $display("FAIL reset_async inst%0d: got %h expected 0", i, dut_snap(i));
         end
      end
      n_chk++;
      if ({data0, data1} !== 16'd0) begin
         n_err++;
         $display("FAIL reset_data: got %h expected 0000", {data0, data1});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         n_chk++;
         if (dut_snap(i) !== mod_snap(i)) begin
            n_err++;
            $display("FAIL reset_first_edge inst%0d: got %h expected %h", i, dut_snap(i),
                     mod_snap(i));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3];
      logic [23:0] got;
      int n;
      int last;
      bit contiguous;
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
      got = 24'd0; n = 0; last = -1; contiguous = 1'b1;
      apply_reset();
      rdy0 = 1'b1;
      for (int c = 0; c < 8; c++) begin
         push0 = (c < 3);
         pd0   = (c < 3) ? bytes[c] : 8'd0;
         tick();
         n_chk++;
         if (dut_snap(0) !== mod_snap(0)) begin
            n_err++;
            $display("FAIL b2b_cycle%0d: got %h expected %h", c, dut_snap(0), mod_snap(0));
         end
         if (valid0) begin
            got = {got[15:0], data0};
            n++;
            if (last >= 0 && c != last + 1) contiguous = 1'b0;
            last = c;
         end
      end
      n_chk++;
      if ({n, contiguous, got} !== {32'd3, 1'b1, 24'h112233}) begin
         n_err++;
         $display("FAIL b2b_stream: got n=%0d contig=%0d bytes=%h expected n=3 contig=1 bytes=112233",
                  n, contiguous, got);
      end
      n_chk++;
      if ({sent0, level0} !== {16'd3, 3'd0}) begin
         n_err++;
         $display("FAIL b2b_end: got sent=%0d level=%0d expected sent=3 level=0", sent0, level0);
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      rdy0 = 1'b0;
      push0 = 1'b1; pd0 = 8'hA5;
      tick();
      push0 = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         n_chk++;
         if ({valid0, data0} !== {1'b1, 8'hA5} || dut_snap(0) !== mod_snap(0)) begin
            n_err++;
            $display("FAIL hold_cycle%0d: got valid=%0d data=%h expected valid=1 data=a5",
                     c, valid0, data0);
         end
         tick();
      end
      rdy0 = 1'b1;
      tick();
      tick();
      tick();
      n_chk++;
      if ({sent0, valid0} !== {16'd1, 1'b0} || dut_snap(0) !== mod_snap(0)) begin
         n_err++;
         $display("FAIL hold_release: got sent=%0d valid=%0d expected sent=1 valid=0",
                  sent0, valid0);
      end
   endtask

   task automatic test_overflow();
      logic [39:0] got;
      int n;
      got = 40'd0; n = 0;
      apply_reset();
      rdy0 = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         push0 = 1'b1; pd0 = 8'(c);
         tick();
      end
      n_chk++;
      if ({valid0, data0, level0, full0, ovf0} !== {1'b1, 8'h01, 3'd4, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL fill: got v=%0d d=%h lvl=%0d full=%0d ovf=%0d expected 1 01 4 1 0",
                  valid0, data0, level0, full0, ovf0);
      end
      pd0 = 8'h06;
      tick();
      push0 = 1'b0;
      n_chk++;
      if ({level0, full0, ovf0} !== {3'd4, 1'b1, 1'b1} || dut_snap(0) !== mod_snap(0)) begin
         n_err++;
         $display("FAIL overflow: got lvl=%0d full=%0d ovf=%0d expected 4 1 1",
                  level0, full0, ovf0);
      end
      rdy0 = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (valid0 && rdy0) begin
            got = {got[31:0], data0};
            n++;
         end
         tick();
      end
      n_chk++;
      if ({n, got} !== {32'd5, 40'h0102030405}) begin
         n_err++;
         $display("FAIL drain: got n=%0d bytes=%h expected n=5 bytes=0102030405", n, got);
      end
   endtask

   task automatic test_gap();
      logic [4:0] pat;
      pat = 5'd0;
      apply_reset();
      rdy1 = 1'b1;
      push1 = 1'b1; pd1 = 8'h3C;
      tick();
      pd1 = 8'hC3;
      tick();
      pat = {pat[3:0], valid1};
      push1 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         pat = {pat[3:0], valid1};
         n_chk++;
         if (dut_snap(1) !== mod_snap(1)) begin
            n_err++;
            $display("FAIL gap_cycle%0d: got %h expected %h", c, dut_snap(1), mod_snap(1));
         end
      end
      n_chk++;
      if ({pat, sent1} !== {5'b10010, 16'd2}) begin
         n_err++;
         $display("FAIL gap_pattern: got %b sent=%0d expected 10010 sent=2", pat, sent1);
      end
   endtask

   task automatic test_reset_mid();
      bit bad;
      bad = 1'b0;
      apply_reset();
      rdy0 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         push0 = 1'b1; pd0 = 8'h40 + 8'(c);
         tick();
      end
      push0 = 1'b0;
      n_chk++;
      if ({valid0, level0} !== {1'b1, 3'd2} || dut_snap(0) !== mod_snap(0)) begin
         n_err++;
         $display("FAIL pre_reset: got valid=%0d level=%0d expected valid=1 level=2",
                  valid0, level0);
      end
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({valid0, level0, sent0, ovf0, full0} !== 22'd0) begin
         n_err++;
         $display("FAIL reset_mid: got v=%0d lvl=%0d sent=%0d ovf=%0d expected all 0",
                  valid0, level0, sent0, ovf0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      rdy0 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (valid0 !== 1'b0 || sent0 !== 16'd0) bad = 1'b1;
      end
      n_chk++;
      if (bad !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_quiet: got activity after reset, expected none");
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 1500; c++) begin
         push0 = 1'($urandom_range(0, 1));
         push1 = 1'($urandom_range(0, 1));
         pd0   = 8'($urandom);
         pd1   = 8'($urandom);
         rdy0  = ($urandom_range(0, 3) != 0);
         rdy1  = ($urandom_range(0, 3) == 0);
         tick();
         for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (dut_snap(i) !== mod_snap(i)) begin
               n_err++;
               $display("FAIL random inst%0d cycle%0d: got %h expected %h", i, c,
                        dut_snap(i), mod_snap(i));
            end
         end
      end
   endtask

   task automatic test_wrap();
      int bad;
      bit saw_wrap;
      logic [15:0] prev;
      bad = 0; saw_wrap = 1'b0; prev = 16'd0;
      apply_reset();
      rdy0 = 1'b1;
      push0 = 1'b1;
      for (int c = 0; c < 65545; c++) begin
         pd0 = 8'(c);
         tick();
         if (dut_snap(0) !== mod_snap(0)) bad++;
         if (prev == 16'hFFFF && sent0 == 16'd0) saw_wrap = 1'b1;
         prev = sent0;
      end
      push0 = 1'b0;
      n_chk++;
      if ({bad, saw_wrap} !== {32'd0, 1'b1}) begin
         n_err++;
         $display("FAIL wrap: got %0d mismatching cycles wrap_seen=%0d expected 0 and 1",
                  bad, saw_wrap);
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_overflow();
      test_gap();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
